bram_stream_writer: RTL and testbench

BRAM_STREAM_WRITER -- requirements
Module: bram_stream_writer

---
 rtl/bram_stream_writer_pkg.sv | 11 +
 rtl/bram_stream_writer.sv | 102 ++++++++++
 tb/tb_bram_stream_writer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bram_stream_writer_pkg.sv
// bram_stream_writer_pkg: shared FSM states, default BRAM word addresses and address helper
package bram_stream_writer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_PUBLISH, S_POLL, S_POLL_WAIT} state_t;
  localparam logic [13:0] DEF_BUF_BASE  = 14'h0010;
  localparam logic [13:0] DEF_HEAD_ADDR = 14'h0000;
  localparam logic [13:0] DEF_TAIL_ADDR = 14'h0001;
  localparam int          DEF_BUF_WORDS = 1024;
  function automatic logic [31:0] byte_addr(input logic [13:0] w);
    return {16'h0000, w, 2'b00};
  endfunction
endpackage

// File: rtl/bram_stream_writer.sv
// bram_stream_writer: streams words into a BRAM circular buffer and publishes the head index
// Ports: CLK/RST clock and async active-high reset; in_valid/in_data/in_ready input stream;
// bramInitiatorWires_* BRAM initiator port (Din is read data for tail polls);
// words_written count of words committed to the buffer.
module bram_stream_writer
  import bram_stream_writer_pkg::*;
#(
  parameter logic [13:0] BUF_BASE  = DEF_BUF_BASE,
  parameter int          BUF_WORDS = DEF_BUF_WORDS,
  parameter logic [13:0] HEAD_ADDR = DEF_HEAD_ADDR,
  parameter logic [13:0] TAIL_ADDR = DEF_TAIL_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] bramInitiatorWires_bramAddr,
  output logic [31:0] bramInitiatorWires_bramDout,
  output logic [3:0]  bramInitiatorWires_bramWEN,
  output logic        bramInitiatorWires_bramEN,
  output logic        bramInitiatorWires_bramCLK,
  output logic        bramInitiatorWires_bramRST,
  input  logic [31:0] bramInitiatorWires_bramDin,
  output logic [31:0] words_written
);
  localparam int AW = $clog2(BUF_WORDS);
  state_t         r_state;
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [31:0]    r_count;
  logic           r_en;
  logic [3:0]     r_wen;
  logic [13:0]    r_waddr;
  logic [31:0]    r_dout;
  logic [AW-1:0]  w_head_nxt;
  logic           w_full;
  logic           w_unused;
  // AW-bit sum wraps modulo BUF_WORDS on its own
  assign w_head_nxt = r_head + AW'(1);
  // one slot is sacrificed so full and empty are distinguishable
  assign w_full     = w_head_nxt == r_tail;
  assign in_ready   = (r_state == S_IDLE) && !w_full;
  assign w_unused   = ^bramInitiatorWires_bramDin[31:AW];
  assign bramInitiatorWires_bramAddr = byte_addr(r_waddr);
  assign bramInitiatorWires_bramDout = r_dout;
  assign bramInitiatorWires_bramWEN  = r_wen;
  assign bramInitiatorWires_bramEN   = r_en;
  assign bramInitiatorWires_bramCLK  = CLK;
  assign bramInitiatorWires_bramRST  = 1'b0;
  assign words_written = r_count;
  // BRAM port outputs are loaded on entry to the state that drives them
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_wen   <= '0;
      r_waddr <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !w_full) begin
            r_state <= S_WRITE;
            r_en    <= 1'b1;
            r_wen   <= 4'hF;
            r_waddr <= BUF_BASE + 14'(r_head);
            r_dout  <= in_data;
          end else if (in_valid) begin
            r_state <= S_POLL;
            r_en    <= 1'b1;
            r_wen   <= 4'h0;
            r_waddr <= TAIL_ADDR;
            r_dout  <= '0;
          end
        end
        S_WRITE: begin
          r_state <= S_PUBLISH;
          r_head  <= w_head_nxt;
          r_count <= r_count + 32'd1;
          r_waddr <= HEAD_ADDR;
          r_dout  <= 32'(w_head_nxt);
        end
        S_PUBLISH, S_POLL: begin
          r_state <= r_state == S_POLL ? S_POLL_WAIT : S_IDLE;
          r_en    <= 1'b0;
          r_wen   <= '0;
          r_waddr <= '0;
          r_dout  <= '0;
        end
        S_POLL_WAIT: begin
          r_state <= S_IDLE;
          r_tail  <= bramInitiatorWires_bramDin[AW-1:0];
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_stream_writer.sv
// tb_bram_stream_writer: directed checks of the BRAM stream writer at depths 4 and 1024
module tb_bram_stream_writer;
  logic        CLK = 1'b0;
  logic        rst4 = 1'b1, rst1k = 1'b1;
  logic        v4 = 1'b0, v1k = 1'b0;
  logic [31:0] d4 = '0, d1k = '0;
  logic        rdy4, rdy1k;
  logic [31:0] addr4, addr1k, dout4, dout1k, din4, cnt4, cnt1k;
  logic [3:0]  wen4, wen1k;
  logic        en4, en1k, bclk4, bclk1k, brst4, brst1k;
  logic [31:0] din1k = '0;
  logic [31:0] tail_word4 = '0;
  int          n_err = 0, n_chk = 0;
  always #5 CLK = ~CLK;
  bram_stream_writer #(.BUF_WORDS(4)) u4 (
    .CLK(CLK), .RST(rst4), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .bramInitiatorWires_bramAddr(addr4), .bramInitiatorWires_bramDout(dout4),
    .bramInitiatorWires_bramWEN(wen4), .bramInitiatorWires_bramEN(en4),
    .bramInitiatorWires_bramCLK(bclk4), .bramInitiatorWires_bramRST(brst4),
    .bramInitiatorWires_bramDin(din4), .words_written(cnt4));
  bram_stream_writer u1k (
    .CLK(CLK), .RST(rst1k), .in_valid(v1k), .in_data(d1k), .in_ready(rdy1k),
    .bramInitiatorWires_bramAddr(addr1k), .bramInitiatorWires_bramDout(dout1k),
    .bramInitiatorWires_bramWEN(wen1k), .bramInitiatorWires_bramEN(en1k),
    .bramInitiatorWires_bramCLK(bclk1k), .bramInitiatorWires_bramRST(brst1k),
    .bramInitiatorWires_bramDin(din1k), .words_written(cnt1k));
  // consumer-side BRAM: only the tail word at byte 0x4 is readable
  always @(posedge CLK) din4 <= (en4 && wen4 == 4'h0 && addr4 == 32'h4) ? tail_word4 : 32'h0;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    int k, npub, last_pub;
    #1;
    chk("rst_en", {31'd0, en1k}, 32'd0);
    chk("rst_wen", {28'd0, wen1k}, 32'd0);
    chk("rst_cnt", cnt1k, 32'd0);
    @(negedge CLK);
    rst4 = 1'b0;
    rst1k = 1'b0;
    step;
    chk("idle_ready", {31'd0, rdy1k}, 32'd1);
    chk("idle_addr", addr1k, 32'd0);
    chk("bram_rst", {31'd0, brst1k}, 32'd0);
    chk("bram_clk", {31'd0, bclk1k}, {31'd0, CLK});
    // single word
    v1k = 1'b1;
    d1k = 32'hDEADBEEF;
    step;
    v1k = 1'b0;
    chk("single_wr_addr", addr1k, 32'h40);
    chk("single_wr_wen", {28'd0, wen1k}, 32'hF);
    chk("single_wr_data", dout1k, 32'hDEADBEEF);
    chk("single_wr_ready", {31'd0, rdy1k}, 32'd0);
    step;
    chk("single_pub_addr", addr1k, 32'h0);
    chk("single_pub_data", dout1k, 32'd1);
    chk("single_pub_wen", {28'd0, wen1k}, 32'hF);
    chk("single_cnt", cnt1k, 32'd1);
    step;
    chk("single_idle_en", {31'd0, en1k}, 32'd0);
    // back-to-back, 10 words with in_valid held
    k = 0;
    npub = 0;
    last_pub = -1;
    d1k = 32'd100;
    v1k = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step;
      if (en1k && addr1k >= 32'h40) begin
        chk("b2b_addr", addr1k, 32'h44 + 32'(4 * k));
        chk("b2b_data", dout1k, 32'd100 + 32'(k));
        k++;
        d1k = 32'd100 + 32'(k);
        if (k == 10) v1k = 1'b0;
      end else if (en1k) begin
        npub++;
        last_pub = c;
      end
    end
    chk("b2b_writes", 32'(k), 32'd10);
    chk("b2b_pubs", 32'(npub), 32'd10);
    chk("b2b_last_pub", 32'(last_pub), 32'd28);
    chk("b2b_cnt", cnt1k, 32'd11);
    // reset during WRITE
    v1k = 1'b1;
    d1k = 32'hCAFE0001;
    step;
    v1k = 1'b0;
    chk("rstmid_wr_addr", addr1k, 32'h6C);
    #2;
    rst1k = 1'b1;
    #1;
    chk("rstmid_en", {31'd0, en1k}, 32'd0);
    chk("rstmid_wen", {28'd0, wen1k}, 32'd0);
    chk("rstmid_cnt", cnt1k, 32'd0);
    @(negedge CLK);
    rst1k = 1'b0;
    v1k = 1'b1;
    d1k = 32'h12345678;
    step;
    v1k = 1'b0;
    chk("rstmid_next_addr", addr1k, 32'h40);
    chk("rstmid_next_data", dout1k, 32'h12345678);
    step;
    chk("rstmid_pub", dout1k, 32'd1);
    step;
    // depth 4: fill three slots with tail at 0
    for (int i = 0; i < 3; i++) begin
      v4 = 1'b1;
      d4 = 32'hA0 + 32'(i);
      step;
      v4 = 1'b0;
      chk("wrap_wr_addr", addr4, 32'h40 + 32'(4 * i));
      chk("wrap_wr_data", dout4, 32'hA0 + 32'(i));
      step;
      chk("wrap_pub", dout4, 32'(i + 1));
      step;
    end
    chk("full_ready", {31'd0, rdy4}, 32'd0);
    v4 = 1'b1;
    d4 = 32'hA3;
    step;
    chk("poll_addr", addr4, 32'h4);
    chk("poll_en", {31'd0, en4}, 32'd1);
    chk("poll_wen", {28'd0, wen4}, 32'd0);
    step;
    chk("pollwait_en", {31'd0, en4}, 32'd0);
    step;
    chk("still_full", {31'd0, rdy4}, 32'd0);
    step;
    chk("repoll_addr", addr4, 32'h4);
    // consumer frees slots; 6 masks to tail 2
    tail_word4 = 32'h0000_0006;
    step;
    step;
    chk("unblock_ready", {31'd0, rdy4}, 32'd1);
    step;
    chk("unblock_wr_addr", addr4, 32'h4C);
    chk("unblock_wr_data", dout4, 32'hA3);
    d4 = 32'hA4;
    step;
    chk("unblock_pub", dout4, 32'd0);
    step;
    step;
    d4 = 32'hFFFF_FFFF;
    #1;
    chk("wrap5_addr", addr4, 32'h40);
    chk("wrap5_data", dout4, 32'hA4);
    v4 = 1'b0;
    step;
    chk("wrap5_pub", dout4, 32'd1);
    step;
    chk("full_again", {31'd0, rdy4}, 32'd0);
    chk("cnt4", cnt4, 32'd5);
    // high garbage bits masked: tail becomes 3
    tail_word4 = 32'hFFFF_FFF7;
    v4 = 1'b1;
    step;
    step;
    v4 = 1'b0;
    step;
    chk("mask_ready", {31'd0, rdy4}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
